// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the shared UART TX FIFO, with an idle-source watchdog.
// Optional per-packet source header byte when UART_TX_SRC_TAG_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int IDLE_TIMEOUT = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     srcValid,
  input  logic [8*NUM_SRC-1:0]   srcData,
  input  logic [NUM_SRC-1:0]     srcLast,
  output logic [NUM_SRC-1:0]     srcReady,
  output logic                   wrEn,
  output logic [7:0]             din,
  input  logic                   full,
  output logic [NUM_SRC-1:0]     grant,
  output logic                   busy,
  output logic                   timeoutErr
);

  localparam int          IW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [15:0] TO_LAST = 16'(IDLE_TIMEOUT - 1);

`ifdef UART_TX_SRC_TAG_EN
  typedef enum logic [1:0] {S_IDLE, S_TAG, S_XFER} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_XFER} state_t;
`endif

  state_t               r_state, w_state_nx;
  logic [NUM_SRC-1:0]   r_grant, w_grant_nx;
  logic [IW-1:0]        r_ptr, w_ptr_nx;
  logic [15:0]          r_cnt, w_cnt_nx;

  logic                 w_any;
  logic [IW-1:0]        w_sel, w_idx;
  logic                 w_gvalid, w_glast;
  logic [7:0]           w_gdata;

  // Nearest requester after ptr wins, so scan from farthest to nearest and keep the last hit.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      w_idx = IW'((int'(r_ptr) + k) % NUM_SRC);
      if (srcValid[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  // Grant is one-hot, so the owner's signals are an AND-OR select.
  always_comb begin
    w_gdata = 8'h00;
    for (int i = 0; i < NUM_SRC; i++)
      if (r_grant[i]) w_gdata = w_gdata | srcData[8*i +: 8];
  end
  assign w_gvalid = |(srcValid & r_grant);
  assign w_glast  = |(srcLast  & r_grant);

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    srcReady   = '0;
    wrEn       = 1'b0;
    din        = 8'h00;
    timeoutErr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant_nx        = '0;
          w_grant_nx[w_sel] = 1'b1;
          w_ptr_nx          = w_sel;
          w_cnt_nx          = '0;
`ifdef UART_TX_SRC_TAG_EN
          w_state_nx        = S_TAG;
`else
          w_state_nx        = S_XFER;
`endif
        end
      end
`ifdef UART_TX_SRC_TAG_EN
      S_TAG: begin
        if (!full) begin
          wrEn       = 1'b1;
          din        = {4'hA, 4'(r_ptr)};
          w_cnt_nx   = '0;
          w_state_nx = S_XFER;
        end
      end
`endif
      S_XFER: begin
        srcReady = r_grant & {NUM_SRC{!full}};
        if (w_gvalid && !full) begin
          wrEn     = 1'b1;
          din      = w_gdata;
          w_cnt_nx = '0;
          if (w_glast) begin
            w_grant_nx = '0;
            w_state_nx = S_IDLE;
          end
        end else if (!w_gvalid) begin
          // Only cycles where the owner withholds data count toward revocation.
          if (r_cnt >= TO_LAST) begin
            timeoutErr = 1'b1;
            w_grant_nx = '0;
            w_cnt_nx   = '0;
            w_state_nx = S_IDLE;
          end else begin
            w_cnt_nx = r_cnt + 16'd1;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= IW'(NUM_SRC - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_ptr   <= w_ptr_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  assign grant = r_grant;
  assign busy  = |r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-source packet queues, a packet-level
// round-robin reference model, and an independent FIFO-write monitor.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   srcValid, srcLast, srcReady, grant;
  logic [8*N-1:0] srcData;
  logic           wrEn, full, busy, timeoutErr;
  logic [7:0]     din;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_SRC(N), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .srcValid(srcValid), .srcData(srcData), .srcLast(srcLast),
    .srcReady(srcReady), .wrEn(wrEn), .din(din), .full(full), .grant(grant),
    .busy(busy), .timeoutErr(timeoutErr)
  );

  typedef struct packed {logic [7:0] d; logic last;} ent_t;

  ent_t       src_q[N][$];
  logic [7:0] exp_q[$];
  int errs = 0, checks = 0, cyc = 0;
  int m_last = N - 1;
  int to_cnt = 0, to_cyc = -1, wd_acc_c = -1;
  bit to_prev = 1'b0;

  bit cfg_rnd_full, cfg_gap, cfg_stall_last, stalled_done;
  int cfg_win_lo, cfg_win_hi, cfg_rst_after, cfg_wd_src;
  int start_c[N], stop_after[N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] hdr(input int s);
    return 8'hA0 | 8'(s);
  endfunction

  task automatic cfg_default();
    cfg_rnd_full = 0; cfg_gap = 0; cfg_stall_last = 0; stalled_done = 0;
    cfg_win_lo = -1; cfg_win_hi = -1; cfg_rst_after = -1; cfg_wd_src = -1;
    for (int i = 0; i < N; i++) begin start_c[i] = 0; stop_after[i] = -1; end
  endtask

  task automatic add_pkt(input int s, input int len);
    ent_t e;
    for (int b = 0; b < len; b++) begin
      e.d = 8'($urandom); e.last = (b == len - 1);
      src_q[s].push_back(e);
    end
  endtask

  // Whole packets in round-robin order among sources that have something pending.
  function automatic void build_exp();
    ent_t tmp[N][$];
    ent_t e;
    int   s;
    bit   any;
    for (int i = 0; i < N; i++) tmp[i] = src_q[i];
    do begin
      any = 0; s = 0;
      for (int k = 1; k <= N; k++) begin
        s = (m_last + k) % N;
        if (tmp[s].size() > 0) begin any = 1; break; end
      end
      if (any) begin
`ifdef UART_TX_SRC_TAG_EN
        exp_q.push_back(hdr(s));
`endif
        do begin
          e = tmp[s].pop_front();
          exp_q.push_back(e.d);
        end while (!e.last);
        m_last = s;
      end
    end while (any);
  endfunction

  task automatic run_phase(input int max_cyc);
    int acc_cnt[N], gap[N];
    int sent_total = 0, full_hold = 0, quiet = 0, c0, rel;
    bit last_acc = 0, last_now, hold_now, pend;
    logic [N-1:0] acc;
    ent_t e;
    for (int i = 0; i < N; i++) begin acc_cnt[i] = 0; gap[i] = 0; end
    c0 = cyc;
    for (int n = 0; ; n++) begin
      if (n >= max_cyc) begin
        errs++; checks++;
        $display("FAIL phase_timeout: got %0d pending bytes expected 0", exp_q.size());
        break;
      end
      @(negedge clk);
      rel = cyc - c0;
      for (int i = 0; i < N; i++) begin
        srcValid[i] = (rel >= start_c[i]) && src_q[i].size() > 0 && gap[i] == 0 &&
                      (stop_after[i] < 0 || acc_cnt[i] < stop_after[i]);
        srcData[8*i +: 8] = srcValid[i] ? src_q[i][0].d : 8'($urandom);
        srcLast[i]        = srcValid[i] ? src_q[i][0].last : 1'($urandom);
      end
      if (cfg_stall_last && !stalled_done && srcValid[0] && srcLast[0] && grant[0]) begin
        full_hold = 3; stalled_done = 1;
      end
      hold_now = full_hold > 0;
      if (hold_now) full_hold--;
      full = hold_now || (rel >= cfg_win_lo && rel < cfg_win_hi) ||
             (cfg_rnd_full && $urandom_range(0, 3) == 0);
      #1;
      acc = srcValid & srcReady;
      if (full)     chk("ready_when_full", 32'(srcReady), 0);
      if (last_acc) chk("gap_after_last", 32'(busy), 0);
      if (hold_now) chk("grant_held_on_last", 32'(grant), 1);
      if (cfg_rst_after >= 0 && sent_total == cfg_rst_after && srcValid[0]) begin
        rst = 1'b1;
        #2;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(srcReady), 0);
        chk("rst_wren", 32'(wrEn), 0);
        chk("rst_din", 32'(din), 0);
        chk("rst_timeout", 32'(timeoutErr), 0);
        exp_q.delete();
        for (int i = 0; i < N; i++) src_q[i].delete();
        m_last = N - 1;
        @(negedge clk);
        srcValid = '0; full = 1'b0;
        rst = 1'b0;
        return;
      end
      last_now = 0;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          e = src_q[i].pop_front();
          acc_cnt[i]++; sent_total++;
          if (i == cfg_wd_src) wd_acc_c = cyc;
          if (e.last) last_now = 1;
          else if (cfg_gap) gap[i] = $urandom_range(0, 3);
        end else if (gap[i] > 0) begin
          gap[i]--;
        end
      end
      last_acc = last_now;
      pend = 0;
      for (int i = 0; i < N; i++)
        if (src_q[i].size() > 0 && (stop_after[i] < 0 || acc_cnt[i] < stop_after[i])) pend = 1;
      quiet = (exp_q.size() == 0 && !pend) ? quiet + 1 : 0;
      if (quiet >= 3) break;
    end
    @(negedge clk);
    srcValid = '0; full = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    cfg_default();
  endtask

  // Monitor: every FIFO write must be the next expected byte.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (wrEn) begin
        chk("wr_while_full", 32'(full), 0);
        if (exp_q.size() == 0) begin
          errs++; checks++;
          $display("FAIL unexpected_write: got %0h expected no write", din);
        end else begin
          chk("fifo_byte", 32'(din), 32'(exp_q.pop_front()));
        end
      end
      if (to_prev) chk("grant_after_timeout", 32'(busy), 0);
      if (timeoutErr) begin to_cnt++; to_cyc = cyc; end
      to_prev = timeoutErr;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    ent_t e;
    logic [7:0] b0, s2b0, s2b1;
    rst = 1'b1; full = 1'b0; srcValid = '0; srcLast = '0; srcData = '0;
    cfg_default();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_grant", 32'(grant), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_ready", 32'(srcReady), 0);
    chk("reset_wren", 32'(wrEn), 0);
    chk("reset_din", 32'(din), 0);
    chk("reset_timeout", 32'(timeoutErr), 0);
    @(negedge clk);
    rst = 1'b0;

    // Contention from reset: packets leave as 0,1,2,3,0.
    add_pkt(0, 2); add_pkt(0, 2); add_pkt(1, 2); add_pkt(2, 2); add_pkt(3, 2);
    build_exp();
    run_phase(200);

    // Single source with fixed bytes.
    e.d = 8'h11; e.last = 0; src_q[0].push_back(e);
    e.d = 8'h22;             src_q[0].push_back(e);
    e.d = 8'h33; e.last = 1; src_q[0].push_back(e);
    build_exp();
    run_phase(100);

    // Backpressure: five full cycles in the middle of a packet.
    add_pkt(2, 6);
    cfg_win_lo = 3; cfg_win_hi = 8;
    build_exp();
    run_phase(100);

    // full rises exactly when the last byte is presented.
    add_pkt(0, 2);
    cfg_stall_last = 1;
    build_exp();
    run_phase(100);
    chk("last_stall_seen", 32'(to_cnt), 0);

    // Watchdog: src1 goes silent after one byte; src2 waits its turn.
    add_pkt(1, 3); add_pkt(2, 2);
    b0 = src_q[1][0].d; s2b0 = src_q[2][0].d; s2b1 = src_q[2][1].d;
    stop_after[1] = 1; start_c[2] = 4; cfg_wd_src = 1;
`ifdef UART_TX_SRC_TAG_EN
    exp_q.push_back(hdr(1));
`endif
    exp_q.push_back(b0);
`ifdef UART_TX_SRC_TAG_EN
    exp_q.push_back(hdr(2));
`endif
    exp_q.push_back(s2b0); exp_q.push_back(s2b1);
    m_last = 2;
    run_phase(200);
    chk("timeout_count", 32'(to_cnt), 1);
    chk("timeout_idle_cycles", 32'(to_cyc - wd_acc_c), TO);

    // Reset while the second byte of a 4-byte packet is offered.
    add_pkt(0, 4);
    cfg_rst_after = 1;
    build_exp();
    run_phase(100);

    // After reset source 0 wins first again.
    for (int i = 0; i < N; i++) add_pkt(i, 1 + i);
    build_exp();
    run_phase(200);

    // Randomized packets, random full and mid-packet source gaps.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++)
        for (int p = $urandom_range(0, 3); p > 0; p--) add_pkt(i, $urandom_range(1, 5));
      cfg_rnd_full = 1; cfg_gap = 1;
      build_exp();
      run_phase(3000);
    end
    chk("no_spurious_timeout", 32'(to_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
